// File: rtl/cpu_memory_arb.sv
// Shared single-port RAM behind a round-robin req/ack arbiter, with a write-protected
// low region (charset) and a clear engine that fills the unprotected region.
module cpu_memory_arb #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 12,
  parameter int CHANNELS    = 2,
  parameter int PROTECT_TOP = 512,
  parameter int CLEAR_VALUE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        req,
  input  logic [CHANNELS-1:0]        write,
  input  logic [CHANNELS*ADDR_W-1:0] addr,
  input  logic [CHANNELS*DATA_W-1:0] wdata,
  output logic [CHANNELS-1:0]        ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       wr_fault,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROTECT_TOP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] CLR_WORD  = DATA_W'(CLEAR_VALUE);
  localparam logic [PTR_W-1:0]  LAST_CH   = PTR_W'(CHANNELS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [CHANNELS-1:0] ack_reg, ack_next;
  logic [DATA_W-1:0]   rdata_reg;
  logic                wr_fault_reg, wr_fault_next;
  logic                clear_done_reg, clear_done_next;
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;

  logic [DATA_W-1:0]   mem_reg [DEPTH];

  logic [ADDR_W-1:0]   ch_addr  [CHANNELS];
  logic [DATA_W-1:0]   ch_wdata [CHANNELS];

  logic [CHANNELS-1:0] eligible;
  logic                arb_valid;
  logic [PTR_W-1:0]    arb_idx;
  logic                grant_valid;
  logic                rd_en;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign ch_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign ch_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // A channel acked this cycle is masked so its held req is not served twice.
  assign eligible = req & ~ack_reg;

  always_comb begin
    logic [PTR_W:0] cand;
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(CHANNELS)) begin
        cand = cand - (PTR_W+1)'(CHANNELS);
      end
      if (!arb_valid && eligible[cand[PTR_W-1:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign sel_addr  = ch_addr[arb_idx];
  assign sel_wdata = ch_wdata[arb_idx];
  assign sel_write = write[arb_idx];

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    clear_done_next = 1'b0;
    grant_valid     = 1'b0;
    ptr_next        = ptr_reg;
    ack_next        = '0;
    wr_fault_next   = 1'b0;
    rd_en           = 1'b0;
    mem_we          = 1'b0;
    mem_waddr       = sel_addr;
    mem_wdata       = sel_wdata;
    case (state_reg)
      ST_IDLE: begin
        // A clear request takes the RAM even when requests are pending.
        if (clear_start) begin
          state_next = ST_CLEAR;
        end else if (arb_valid) begin
          grant_valid = 1'b1;
          ack_next    = CHANNELS'(1) << arb_idx;
          ptr_next    = (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;
          if (!sel_write) begin
            rd_en = 1'b1;
          end else if (sel_addr < PROT_ADDR) begin
            wr_fault_next = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_reg;
        mem_wdata = CLR_WORD;
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next      = ST_IDLE;
          clear_done_next = 1'b1;
          clr_cnt_next    = PROT_ADDR;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
      wr_fault_reg   <= 1'b0;
      clear_done_reg <= 1'b0;
      clr_cnt_reg    <= PROT_ADDR;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      ack_reg        <= ack_next;
      wr_fault_reg   <= wr_fault_next;
      clear_done_reg <= clear_done_next;
      clr_cnt_reg    <= clr_cnt_next;
      if (rd_en) begin
        rdata_reg <= mem_reg[sel_addr];
      end else if (grant_valid) begin
        rdata_reg <= '0;
      end
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_reg[mem_waddr] <= mem_wdata;
    end
  end

  assign ack        = ack_reg;
  assign rdata      = rdata_reg;
  assign wr_fault   = wr_fault_reg;
  assign clear_busy = (state_reg == ST_CLEAR);
  assign clear_done = clear_done_reg;

endmodule

// File: tb/tb_cpu_memory_arb.sv
// Directed + randomized bench for cpu_memory_arb against a behavioural memory/arbiter model.
module tb_cpu_memory_arb;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int NCH   = 2;
  localparam int PTOP  = 512;
  localparam int DEPTH = 4096;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NCH-1:0]  req = '0;
  logic [NCH-1:0]  write = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic [NCH-1:0]  ack;
  logic [DW-1:0]   rdata;
  logic            wr_fault;
  logic            clear_start = 1'b0;
  logic            clear_busy;
  logic            clear_done;

  always #5 clk = ~clk;

  cpu_memory_arb #(
    .DATA_W(DW), .ADDR_W(AW), .CHANNELS(NCH), .PROTECT_TOP(PTOP), .CLEAR_VALUE(0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .wr_fault(wr_fault), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  logic [7:0] model_mem   [DEPTH];
  bit         model_known [DEPTH];
  int         ptr_model = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Single request on one channel with everything else idle.
  task automatic do_access(input int ch, input bit wr, input logic [11:0] a,
                           input logic [7:0] d, output logic [7:0] got);
    int lat;
    bit exp_fault;
    exp_fault = wr && (a < PTOP);
    req[ch] = 1'b1;
    write[ch] = wr;
    addr[ch*AW +: AW] = a;
    wdata[ch*DW +: DW] = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (ack == '0 && lat < 8);
    check("latency", lat, 1);
    check("ack", ack, 1 << ch);
    check("wr_fault", wr_fault, exp_fault);
    if (wr) check("rdata_on_write", rdata, 0);
    else if (model_known[a]) check("rdata", rdata, model_mem[a]);
    got = rdata;
    $display("t=%0t ch=%0d %s addr=%03h wdata=%02h rdata=%02h fault=%0b lat=%0d",
             $time, ch, wr ? "WR" : "RD", a, d, rdata, wr_fault, lat);
    req[ch] = 1'b0;
    if (wr && !exp_fault) begin
      model_mem[a] = d;
      model_known[a] = 1'b1;
    end
    ptr_model = (ch + 1) % NCH;
    @(negedge clk);
    check("ack_pulse", ack, 0);
  endtask

  // Both channels request together; order follows the round-robin pointer.
  task automatic do_pair(input bit w0, input logic [11:0] a0, input logic [7:0] d0,
                         input bit w1, input logic [11:0] a1, input logic [7:0] d1);
    bit wv[2];
    logic [11:0] av[2];
    logic [7:0] dv[2];
    int first, ch, lat;
    bit exp_fault;
    wv[0] = w0; av[0] = a0; dv[0] = d0;
    wv[1] = w1; av[1] = a1; dv[1] = d1;
    for (int c = 0; c < NCH; c++) begin
      req[c] = 1'b1;
      write[c] = wv[c];
      addr[c*AW +: AW] = av[c];
      wdata[c*DW +: DW] = dv[c];
    end
    first = ptr_model;
    for (int step = 0; step < 2; step++) begin
      ch = (step == 0) ? first : 1 - first;
      lat = 0;
      do begin @(negedge clk); lat++; end while (ack == '0 && lat < 8);
      exp_fault = wv[ch] && (av[ch] < PTOP);
      check("pair_latency", lat, 1);
      check("pair_ack", ack, 1 << ch);
      check("pair_fault", wr_fault, exp_fault);
      check("pair_rdata", rdata, wv[ch] ? 8'h00 : model_mem[av[ch]]);
      $display("t=%0t pair ch=%0d %s addr=%03h wdata=%02h rdata=%02h fault=%0b",
               $time, ch, wv[ch] ? "WR" : "RD", av[ch], dv[ch], rdata, wr_fault);
      req[ch] = 1'b0;
      if (wv[ch] && !exp_fault) model_mem[av[ch]] = dv[ch];
      ptr_model = (ch + 1) % NCH;
    end
    @(negedge clk);
    check("pair_idle", ack, 0);
  endtask

  initial begin
    logic [7:0] tmp, font, font1ff;
    logic [11:0] ra0, ra1;
    bit rw0, rw1;
    int busy_cnt, done_cnt, early_ack, bad;

    for (int a = 0; a < DEPTH; a++) begin
      model_known[a] = 1'b0;
      model_mem[a] = 8'h00;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_fault", wr_fault, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Both channels hold req: grants alternate starting at channel 0
    req = 2'b11; write = 2'b11;
    addr[0 +: AW] = 12'h400; wdata[0 +: DW] = 8'h11;
    addr[AW +: AW] = 12'h401; wdata[DW +: DW] = 8'h22;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_ack", ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_fault", wr_fault, 0);
      check("rr_rdata", rdata, 0);
      $display("t=%0t rr cycle=%0d ack=%02b", $time, k, ack);
    end
    req = 2'b00;
    model_mem[12'h400] = 8'h11; model_known[12'h400] = 1'b1;
    model_mem[12'h401] = 8'h22; model_known[12'h401] = 1'b1;
    ptr_model = 0;
    @(negedge clk);

    // Basic write/read on channel 0
    do_access(0, 1'b1, 12'h300, 8'hA5, tmp);
    do_access(0, 1'b0, 12'h300, 8'h00, tmp);
    do_access(1, 1'b0, 12'h401, 8'h00, tmp);

    // Protected write leaves the charset byte intact
    do_access(1, 1'b0, 12'h010, 8'h00, font);
    do_access(1, 1'b1, 12'h010, 8'h55, tmp);
    do_access(1, 1'b0, 12'h010, 8'h00, tmp);
    check("font_kept", tmp, font);

    // Clear engine, with a request and a second clear_start while busy
    do_access(0, 1'b1, 12'h200, 8'h77, tmp);
    do_access(0, 1'b1, 12'hFFF, 8'h77, tmp);
    do_access(1, 1'b0, 12'h1FF, 8'h00, font1ff);
    do_access(1, 1'b1, 12'h1FF, 8'h33, tmp);
    busy_cnt = 0; done_cnt = 0; early_ack = 0;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (!clear_busy) break;
      busy_cnt++;
      if (ack != '0) early_ack++;
      if (clear_done) done_cnt++;
      if (busy_cnt == 50) begin
        req[0] = 1'b1; write[0] = 1'b0; addr[0 +: AW] = 12'h300;
      end
      clear_start = (busy_cnt == 60);
      @(negedge clk);
    end
    clear_start = 1'b0;
    check("clear_busy_cycles", busy_cnt, 3584);
    check("clear_done_at_end", clear_done, 1);
    check("ack_first_idle", ack, 0);
    for (int a = PTOP; a < DEPTH; a++) begin
      model_mem[a] = 8'h00;
      model_known[a] = 1'b1;
    end
    @(negedge clk);
    check("ack_after_clear", ack, 2'b01);
    check("rdata_after_clear", rdata, model_mem[12'h300]);
    check("clear_done_pulse", clear_done, 0);
    check("clear_done_count", done_cnt, 0);
    check("ack_during_clear", early_ack, 0);
    $display("t=%0t clear busy_cycles=%0d held_req_ack=%02b", $time, busy_cnt, ack);
    req[0] = 1'b0;
    ptr_model = 1;
    @(negedge clk);
    do_access(0, 1'b0, 12'h200, 8'h00, tmp);
    do_access(1, 1'b0, 12'hFFF, 8'h00, tmp);
    do_access(1, 1'b0, 12'h1FF, 8'h00, tmp);
    check("charset_survives_clear", tmp, font1ff);

    // Randomized single-channel traffic
    for (int n = 0; n < 30; n++) begin
      rw0 = 1'($urandom_range(0, 1));
      ra0 = rw0 ? 12'($urandom_range(0, DEPTH-1)) : 12'($urandom_range(PTOP, DEPTH-1));
      do_access($urandom_range(0, 1), rw0, ra0, 8'($urandom), tmp);
    end

    // Randomized simultaneous requests, sometimes to the same address
    for (int n = 0; n < 15; n++) begin
      rw0 = 1'($urandom_range(0, 1));
      rw1 = 1'($urandom_range(0, 1));
      ra0 = 12'($urandom_range(PTOP, DEPTH-1));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 12'($urandom_range(PTOP, DEPTH-1));
      if (rw0 && $urandom_range(0, 5) == 0) ra0 = 12'($urandom_range(0, PTOP-1));
      do_pair(rw0, ra0, 8'($urandom), rw1, ra1, 8'($urandom));
    end

    // Reset 100 cycles into a clear; clear_start coincides with a pending req
    do_access(0, 1'b1, 12'h200, 8'hE1, tmp);
    do_access(0, 1'b1, 12'h263, 8'hE2, tmp);
    do_access(1, 1'b1, 12'h264, 8'hE3, tmp);
    clear_start = 1'b1;
    req[1] = 1'b1; write[1] = 1'b0; addr[AW +: AW] = 12'h300;
    @(negedge clk);
    clear_start = 1'b0;
    check("coincide_ack", ack, 0);
    check("coincide_busy", clear_busy, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ack != '0 || clear_done) bad++;
    end
    reset = 1'b1;
    req = '0;
    #1;
    check("abort_busy", clear_busy, 0);
    check("abort_done", clear_done, 0);
    check("abort_ack", ack, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (clear_done || clear_busy) bad++;
    end
    check("abort_quiet", bad, 0);
    $display("t=%0t clear aborted by reset", $time);
    for (int a = 12'h200; a <= 12'h263; a++) model_mem[a] = 8'h00;
    ptr_model = 0;
    do_access(0, 1'b0, 12'h200, 8'h00, tmp);
    do_access(1, 1'b0, 12'h231, 8'h00, tmp);
    do_access(0, 1'b0, 12'h263, 8'h00, tmp);
    do_access(1, 1'b0, 12'h264, 8'h00, tmp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
